seq_divider: RTL and testbench

Iterative radix-2 restoring divider for the 32-bit arithmetic calculator. It computes quotient and remainder for unsigned or signed operands, one quotient bit per clock. It is the inverse-direction datapath to the compressor-tree multiplier and sits beside it behind the same operand/result valid/ready handshake. It trades latency for area: a single WIDTH+1-bit subtractor is reused for every iteration.

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/seq_divider_step.sv | 31 +++
 rtl/seq_divider.sv | 151 +++++++++++++++
 tb/tb_seq_divider.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Bits needed for a step counter that runs 0..width-1.
  function automatic int div_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration built around a single WIDTH+1-bit subtract.
import div_pkg::*;

module div_step #(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;
  logic           no_borrow_s;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted_s   = {rem_in, bit_in};
    diff_s      = shifted_s - {1'b0, dvsr};
    no_borrow_s = ~diff_s[WIDTH];
    q_bit       = no_borrow_s;
    if (no_borrow_s) begin
      rem_out = diff_s[WIDTH-1:0];
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per clock.
import div_pkg::*;

module seq_divider #(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int             CW       = div_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  div_state_e       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;       // partial remainder
  logic [WIDTH-1:0] dvd_r;       // dividend magnitude, becomes quotient as bits shift in
  logic [WIDTH-1:0] dvsr_r;      // divisor magnitude
  logic             sop_r;
  logic             dvd_neg_r;
  logic             dvsr_neg_r;

  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvsr_mag_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[WIDTH-1]),
    .dvsr    (dvsr_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Operand magnitudes: absolute value only for negative signed operands.
  always_comb begin
    if (signed_op && dividend[WIDTH-1]) begin
      dvd_mag_s = {WIDTH{1'b0}} - dividend;
    end else begin
      dvd_mag_s = dividend;
    end
    if (signed_op && divisor[WIDTH-1]) begin
      dvsr_mag_s = {WIDTH{1'b0}} - divisor;
    end else begin
      dvsr_mag_s = divisor;
    end
  end

  // Sign correction: quotient negative on sign mismatch, remainder follows dividend.
  always_comb begin
    if (sop_r && (dvd_neg_r ^ dvsr_neg_r)) begin
      quo_fix_s = {WIDTH{1'b0}} - dvd_r;
    end else begin
      quo_fix_s = dvd_r;
    end
    if (sop_r && dvd_neg_r) begin
      rem_fix_s = {WIDTH{1'b0}} - rem_r;
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // Control FSM, iteration datapath and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      rem_r        <= {WIDTH{1'b0}};
      dvd_r        <= {WIDTH{1'b0}};
      dvsr_r       <= {WIDTH{1'b0}};
      sop_r        <= 1'b0;
      dvd_neg_r    <= 1'b0;
      dvsr_neg_r   <= 1'b0;
      start_ready  <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      quotient     <= {WIDTH{1'b0}};
      remainder    <= {WIDTH{1'b0}};
      div_by_zero  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            sop_r       <= signed_op;
            dvd_neg_r   <= dividend[WIDTH-1];
            dvsr_neg_r  <= divisor[WIDTH-1];
            dvd_r       <= dvd_mag_s;
            dvsr_r      <= dvsr_mag_s;
            rem_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            start_ready <= 1'b0;
            busy        <= 1'b1;
            if (divisor == {WIDTH{1'b0}}) begin
              quotient     <= {WIDTH{1'b1}};
              remainder    <= dividend;
              div_by_zero  <= 1'b1;
              result_valid <= 1'b1;
              state_r      <= DONE;
            end else begin
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= step_rem_s;
          dvd_r <= {dvd_r[WIDTH-2:0], step_q_s};
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          quotient     <= quo_fix_s;
          remainder    <= rem_fix_s;
          div_by_zero  <= 1'b0;
          result_valid <= 1'b1;
          state_r      <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          start_ready  <= 1'b1;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        signed_op;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .signed_op    (signed_op),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, C-style truncation toward zero.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // One full transaction: accept, latency/busy check, result check, optional
  // back-pressure hold and a stray start_valid pulse mid-calculation.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int hold, input bit glitch);
    logic [31:0] eq, er;
    logic        ez;
    int          n;
    bit          busy_ok, stable_ok, sr_ok;
    ref_div(a, b, s, eq, er, ez);
    @(negedge clk);
    check({tag, ":start_ready"}, 64'(start_ready), 64'd1);
    start_valid = 1'b1; dividend = a; divisor = b; signed_op = s;
    @(posedge clk); #1;
    start_valid = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
    n = 0; busy_ok = 1'b1;
    while (n < 100) begin
      if (busy !== 1'b1 || start_ready !== 1'b0) busy_ok = 1'b0;
      if (glitch && n == 5) begin
        start_valid = 1'b1; dividend = 32'h0000_DEAD; divisor = 32'd3;
      end else begin
        start_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (result_valid === 1'b1) break;
    end
    start_valid = 1'b0;
    check({tag, ":latency"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    check({tag, ":busy"}, 64'(busy_ok), 64'd1);
    check({tag, ":quotient"}, 64'(quotient), 64'(eq));
    check({tag, ":remainder"}, 64'(remainder), 64'(er));
    check({tag, ":div_by_zero"}, 64'(div_by_zero), 64'(ez));
    stable_ok = 1'b1; sr_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez || result_valid !== 1'b1)
        stable_ok = 1'b0;
      if (start_ready !== 1'b0) sr_ok = 1'b0;
    end
    if (hold > 0) begin
      check({tag, ":hold_stable"}, 64'(stable_ok), 64'd1);
      check({tag, ":hold_start_ready"}, 64'(sr_ok), 64'd1);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({tag, ":rv_drop"}, 64'(result_valid), 64'd0);
    check({tag, ":sr_rise"}, 64'(start_ready), 64'd1);
    check({tag, ":busy_drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
    dividend = 32'd0; divisor = 32'd0; signed_op = 1'b0;
    #12;
    check("reset:start_ready", 64'(start_ready), 64'd1);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:result_valid", 64'(result_valid), 64'd0);
    check("reset:quotient", 64'(quotient), 64'd0);
    check("reset:remainder", 64'(remainder), 64'd0);
    check("reset:div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
    run_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
    run_op("u5_0", 32'd5, 32'd0, 1'b0, 0, 1'b0);
    run_op("s5_0", 32'd5, 32'd0, 1'b1, 0, 1'b0);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
    run_op("bp_glitch", 32'd1000, 32'd33, 1'b0, 5, 1'b1);

    // Reset in the middle of a calculation discards it.
    @(negedge clk);
    start_valid = 1'b1; dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0;
    @(posedge clk); #1; start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst:start_ready", 64'(start_ready), 64'd1);
    check("midrst:busy", 64'(busy), 64'd0);
    check("midrst:result_valid", 64'(result_valid), 64'd0);
    check("midrst:quotient", 64'(quotient), 64'd0);
    check("midrst:remainder", 64'(remainder), 64'd0);
    check("midrst:div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midrst:idle_rv", 64'(result_valid), 64'd0);
    run_op("after_rst", 32'd100, 32'd7, 1'b0, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 15));
        1: rb = 32'($urandom_range(0, 1)) ? 32'd0 : 32'hFFFF_FFFF;
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", k), ra, rb, 1'($urandom), $urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
